// File: rtl/lampFPU_pkg.sv
// Shared FPU constants and helpers.
//   LAMP_FLOAT_F_DW : fraction width of the FPU float format (hidden bit excluded)
//   LAMP_MUL_BPC    : multiplier bits retired per cycle by the iterative fraction multiplier
//   FUNC_mulSteps   : number of iterations needed to retire a w-bit multiplier at bpc bits/cycle
package lampFPU_pkg;

  localparam int unsigned LAMP_FLOAT_F_DW = 7;
  localparam int unsigned LAMP_MUL_BPC    = 1;

  function automatic int unsigned FUNC_mulSteps(input int unsigned w, input int unsigned bpc);
    return (w + bpc - 1) / bpc;
  endfunction

endpackage

// File: rtl/lamp_fpu_mul_step.sv
// Combinational partial-product step of the shift-and-add fraction multiplier.
// Adds (mcand << j) to the accumulator for every set bit j of the retired
// multiplier slice. Result is modulo 2^(2W).
//   acc      : current accumulator
//   mcand    : current (already shifted) multiplicand
//   mplr_lsb : the BPC multiplier bits retired this cycle
//   acc_nxt  : updated accumulator
module lamp_fpu_mul_step #(
  parameter int unsigned W   = 8,
  parameter int unsigned BPC = 1
) (
  input  logic [2*W-1:0] acc,
  input  logic [2*W-1:0] mcand,
  input  logic [BPC-1:0] mplr_lsb,
  output logic [2*W-1:0] acc_nxt
);

  always_comb begin
    acc_nxt = acc;
    for (int unsigned j = 0; j < BPC; j++) begin
      if (mplr_lsb[j]) begin
        acc_nxt = acc_nxt + (mcand << j);
      end
    end
  end

endmodule

// File: rtl/lamp_fpu_fract_mul.sv
// Iterative unsigned shift-and-add multiplier for normalized significands.
// Retires BPC multiplier bits per cycle; a product takes N = ceil(W/BPC)
// cycles, a zero operand completes in one cycle without entering MUL.
//   clk, rst : clock, synchronous active-high reset
//   doMul_i  : start request, sampled only in IDLE
//   a_i, b_i : multiplicand / multiplier significands (1+F_DW bits)
//   res_o    : registered exact product, held until the next completion
//   valid_o  : one-cycle completion pulse
//   busy_o   : high while a multiply is in flight
module lamp_fpu_fract_mul
  import lampFPU_pkg::*;
#(
  parameter int unsigned F_DW = LAMP_FLOAT_F_DW,
  parameter int unsigned BPC  = LAMP_MUL_BPC
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  doMul_i,
  input  logic [F_DW:0]         a_i,
  input  logic [F_DW:0]         b_i,
  output logic [2*(1+F_DW)-1:0] res_o,
  output logic                  valid_o,
  output logic                  busy_o
);

  localparam int unsigned W     = 1 + F_DW;
  localparam int unsigned N     = FUNC_mulSteps(W, BPC);
  localparam int unsigned CNT_W = $clog2(N + 1);

  typedef enum logic {IDLE, MUL} ssFractMul_t;

  ssFractMul_t        ss;
  logic [2*W-1:0]     acc;
  logic [2*W-1:0]     mcand;
  logic [W-1:0]       mplr;
  logic [CNT_W-1:0]   cnt;
  logic [2*W-1:0]     acc_nxt;

  lamp_fpu_mul_step #(
    .W   (W),
    .BPC (BPC)
  ) u_step (
    .acc      (acc),
    .mcand    (mcand),
    .mplr_lsb (mplr[BPC-1:0]),
    .acc_nxt  (acc_nxt)
  );

  assign busy_o = (ss == MUL);

  always_ff @(posedge clk) begin
    if (rst) begin
      ss      <= IDLE;
      acc     <= '0;
      mcand   <= '0;
      mplr    <= '0;
      cnt     <= '0;
      res_o   <= '0;
      valid_o <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      case (ss)
        IDLE: begin
          if (doMul_i) begin
            if ((a_i == '0) || (b_i == '0)) begin
              // zero early-out: product known without iterating
              res_o   <= '0;
              valid_o <= 1'b1;
            end else begin
              acc   <= '0;
              mcand <= {{W{1'b0}}, a_i};
              mplr  <= b_i;
              cnt   <= '0;
              ss    <= MUL;
            end
          end
        end
        MUL: begin
          acc   <= acc_nxt;
          mcand <= mcand << BPC;
          mplr  <= mplr >> BPC;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(N - 1)) begin
            // publish the updated accumulator directly, saving one cycle
            res_o   <= acc_nxt;
            valid_o <= 1'b1;
            ss      <= IDLE;
          end
        end
        default: ss <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lamp_fpu_fract_mul.sv
// Self-checking bench: two instances (BPC=1 and BPC=2, F_DW=7) checked
// against a plain a*b reference with latency derived from ceil(8/BPC).
module tb_lamp_fpu_fract_mul;

  logic        clk = 1'b0;
  logic        rst;
  logic        do_mul [2];
  logic [7:0]  a_in   [2];
  logic [7:0]  b_in   [2];
  logic [15:0] res    [2];
  logic        valid  [2];
  logic        busy   [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lamp_fpu_fract_mul #(.F_DW(7), .BPC(1)) dut1 (
    .clk(clk), .rst(rst), .doMul_i(do_mul[0]), .a_i(a_in[0]), .b_i(b_in[0]),
    .res_o(res[0]), .valid_o(valid[0]), .busy_o(busy[0])
  );

  lamp_fpu_fract_mul #(.F_DW(7), .BPC(2)) dut2 (
    .clk(clk), .rst(rst), .doMul_i(do_mul[1]), .a_i(a_in[1]), .b_i(b_in[1]),
    .res_o(res[1]), .valid_o(valid[1]), .busy_o(busy[1])
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [8];

  function automatic int steps(input int d);
    int bpc;
    bpc = d + 1;
    return (8 + bpc - 1) / bpc;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // From the current sample point (#1 after an edge), wait for valid.
  // lat counts edges advanced; bcnt counts sample points with busy high.
  task automatic wait_valid(input int d, output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    while (!valid[d] && lat < 30) begin
      if (busy[d]) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    if (!valid[d]) chk("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_op(input int d, input logic [7:0] av, input logic [7:0] bv,
                       input logic [15:0] exp);
    int lat, bcnt, n;
    n = ((av == 0) || (bv == 0)) ? 0 : steps(d);
    @(negedge clk);
    a_in[d] = av; b_in[d] = bv; do_mul[d] = 1'b1;
    @(posedge clk); #1;
    do_mul[d] = 1'b0;
    wait_valid(d, lat, bcnt);
    chk($sformatf("res d%0d %0h*%0h", d, av, bv), res[d], exp);
    chk($sformatf("lat d%0d %0h*%0h", d, av, bv), lat, n);
    chk($sformatf("busycnt d%0d %0h*%0h", d, av, bv), bcnt, n);
    chk($sformatf("busy_at_valid d%0d", d), busy[d], 1'b0);
    @(posedge clk); #1;
    chk($sformatf("valid_pulse d%0d", d), valid[d], 1'b0);
    chk($sformatf("hold d%0d", d), res[d], exp);
  endtask

  initial begin
    int lat, bcnt, vcnt;
    logic [7:0] ra, rb;

    vecs[0] = '{8'h80, 8'h80, 16'h4000};
    vecs[1] = '{8'hFF, 8'hFF, 16'hFE01};
    vecs[2] = '{8'hC0, 8'hA0, 16'h7800};
    vecs[3] = '{8'h00, 8'h95, 16'h0000};
    vecs[4] = '{8'h95, 8'h00, 16'h0000};
    vecs[5] = '{8'h01, 8'h01, 16'h0001};
    vecs[6] = '{8'h80, 8'hFF, 16'h7F80};
    vecs[7] = '{8'hFF, 8'h01, 16'h00FF};

    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      do_mul[d] = 1'b0; a_in[d] = '0; b_in[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset res d%0d", d), res[d], 16'h0);
      chk($sformatf("reset valid d%0d", d), valid[d], 1'b0);
      chk($sformatf("reset busy d%0d", d), busy[d], 1'b0);
    end
    rst = 1'b0;

    // table vectors on both instances
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 8; i++)
        do_op(d, vecs[i].a, vecs[i].b, vecs[i].exp);

    // long hold check after a mixed product
    do_op(0, 8'hC0, 8'hA0, 16'h7800);
    repeat (5) @(posedge clk);
    #1;
    chk("long_hold", res[0], 16'h7800);

    // request while busy is ignored; request in the valid cycle is accepted
    @(negedge clk);
    a_in[0] = 8'hFF; b_in[0] = 8'hFF; do_mul[0] = 1'b1;
    @(posedge clk); #1;
    do_mul[0] = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    a_in[0] = 8'h80; b_in[0] = 8'h80; do_mul[0] = 1'b1;
    @(posedge clk); #1;
    do_mul[0] = 1'b0;
    wait_valid(0, lat, bcnt);
    chk("busy_req res", res[0], 16'hFE01);
    chk("busy_req lat", lat, 4);
    a_in[0] = 8'hC0; b_in[0] = 8'hA0; do_mul[0] = 1'b1;
    @(posedge clk); #1;
    do_mul[0] = 1'b0;
    chk("b2b accepted busy", busy[0], 1'b1);
    chk("b2b first res held", res[0], 16'hFE01);
    wait_valid(0, lat, bcnt);
    chk("b2b res", res[0], 16'h7800);
    chk("b2b lat", lat, 8);

    // reset mid-operation
    @(negedge clk);
    a_in[0] = 8'h80; b_in[0] = 8'h80; do_mul[0] = 1'b1;
    @(posedge clk); #1;
    do_mul[0] = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst res", res[0], 16'h0);
    chk("midrst busy", busy[0], 1'b0);
    chk("midrst valid", valid[0], 1'b0);
    vcnt = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (valid[0]) vcnt++;
    end
    chk("midrst no valid", vcnt, 0);

    // reset and request in the same cycle: request dropped
    @(negedge clk);
    rst = 1'b1; a_in[1] = 8'hFF; b_in[1] = 8'hFF; do_mul[1] = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; do_mul[1] = 1'b0;
    chk("rst_and_req busy", busy[1], 1'b0);
    vcnt = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (valid[1] || busy[1]) vcnt++;
    end
    chk("rst_and_req dropped", vcnt, 0);

    // randomized operands against a*b
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 25; i++) begin
        ra = 8'($urandom_range(0, 255));
        rb = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 9) == 0) ra = 8'h00;
        do_op(d, ra, rb, 16'(ra) * 16'(rb));
      end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
